// File: rtl/inst_mem_loader.sv
// Instruction memory loader: takes a little-endian word-count header plus instruction
// bytes and writes each assembled 32-bit word to consecutive word-aligned addresses.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// LEN   | collecting the 4-byte word-count header
// DATA  | assembling words and issuing one write per word
// DONE  | one-cycle done pulse, then back to IDLE
module inst_mem_loader #(
  parameter int n           = 32,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int IDXW = $clog2(DEPTH_WORDS + 1);
  localparam logic [n-1:0] BASE_N = n'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      byte_cnt;
  logic [IDXW-1:0] word_idx;
  logic [31:0]     len_q;
  logic [23:0]     part_q;
  logic            err_q;
  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic [31:0]     len_full;

  // Acceptance is derived from state alone to keep it independent of the in_ready mux.
  assign accept = in_valid && ((state == LEN) || (state == DATA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    len_full  = {in_data, len_q[31:8]};
    last_byte = accept && (byte_cnt == 2'd3);
    last_word = ((32'(word_idx) + 32'd1) == len_q);
    case (state)
      IDLE: if (start) state_nxt = LEN;
      LEN: begin
        in_ready = 1'b1;
        if (last_byte) begin
          if (len_full == 32'd0 || len_full > 32'(DEPTH_WORDS)) state_nxt = DONE;
          else                                                  state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (last_byte && last_word) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt  <= 2'd0;
      word_idx  <= '0;
      len_q     <= 32'd0;
      part_q    <= 24'd0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            byte_cnt <= 2'd0;
            word_idx <= '0;
            len_q    <= 32'd0;
            part_q   <= 24'd0;
            err_q    <= 1'b0;
          end
        end
        LEN: begin
          if (accept) begin
            len_q    <= len_full;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3 && len_full > 32'(DEPTH_WORDS)) err_q <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            part_q   <= {in_data, part_q[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= n'({in_data, part_q});
              mem_addr  <= BASE_N + (n'(word_idx) << 2);
              word_idx  <= word_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: byte-position reference model checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_inst_mem_loader;

  localparam int          N_W   = 32;
  localparam logic [31:0] BASE  = 32'h100;
  localparam int          DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_ready;
  logic            mem_we;
  logic [N_W-1:0]  mem_addr;
  logic [N_W-1:0]  mem_wdata;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int failures = 0;

  inst_mem_loader #(.n(N_W), .BASE_ADDR(32'h100), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the session purely by how many bytes have arrived.
  logic        exp_ready = 0, exp_we = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic        m_sess = 0, m_fin = 0;
  int          m_cnt = 0;
  int          m_writes = 0;
  logic [31:0] m_n = 0, m_word = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_sess = 0; m_fin = 0; m_cnt = 0; m_n = 0; m_word = 0;
      exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_err = 0;
    end else begin
      exp_we = 0;
      if (m_fin) begin
        m_fin = 0; m_sess = 0;
      end else if (!m_sess) begin
        if (start) begin
          m_sess = 1; m_cnt = 0; m_n = 0; m_word = 0; exp_err = 0;
        end
      end else if (in_valid) begin
        if (m_cnt < 4) m_n = m_n | (32'(in_data) << (8 * m_cnt));
        else           m_word = m_word | (32'(in_data) << (8 * ((m_cnt - 4) % 4)));
        m_cnt++;
        if (m_cnt == 4) begin
          if (m_n == 0) m_fin = 1;
          else if (m_n > 32'(DEPTH)) begin exp_err = 1; m_fin = 1; end
        end else if (m_cnt > 4 && (m_cnt - 4) % 4 == 0) begin
          exp_we    = 1;
          exp_addr  = BASE + 32'(4 * ((m_cnt - 4) / 4 - 1));
          exp_wdata = m_word;
          m_word    = 0;
          m_writes++;
          if ((m_cnt - 4) / 4 == int'(m_n)) m_fin = 1;
        end
      end
    end
    exp_ready = m_sess && !m_fin;
    exp_busy  = m_sess;
    exp_done  = m_fin;
  end

  // Every-cycle comparison plus a log of DUT writes for the literal checks.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic        wdone[$];

  initial forever begin
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("mem_we",   64'(mem_we),   64'(exp_we));
    chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
    chk("mem_wdata",64'(mem_wdata),64'(exp_wdata));
    chk("busy",     64'(busy),     64'(exp_busy));
    chk("done",     64'(done),     64'(exp_done));
    chk("err",      64'(err),      64'(exp_err));
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wdone.push_back(done);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin tick(); t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high byte=%0h", b);
    end
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  int base_n;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd0);

    // Two-word load
    do_start();
    chk("len_ready", 64'(in_ready), 64'd1);
    send_word(32'h0000_0002, 0);
    send_word(32'h00A0_0013, 0);
    send_word(32'h0010_8093, 0);
    chk("t1_done_with_last", 64'(done), 64'd1);
    tick();
    chk("t1_nwrites", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      chk("t1_addr0", 64'(wa[0]), 64'h100);
      chk("t1_data0", 64'(wd[0]), 64'h00A0_0013);
      chk("t1_addr1", 64'(wa[1]), 64'h104);
      chk("t1_data1", 64'(wd[1]), 64'h0010_8093);
      chk("t1_done0", 64'(wdone[0]), 64'd0);
      chk("t1_done1", 64'(wdone[1]), 64'd1);
    end
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_model_writes", 64'(m_writes), 64'd2);
    tick();

    // Zero length
    base_n = wa.size();
    do_start();
    send_word(32'h0, 0);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    tick();
    chk("t2_busy_low", 64'(busy), 64'd0);
    chk("t2_done_low", 64'(done), 64'd0);
    chk("t2_nwrites", 64'(wa.size() - base_n), 64'd0);

    // Oversize header, N = 257
    do_start();
    send(8'h01, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_err", 64'(err), 64'd1);
    repeat (3) tick();
    chk("t3_err_sticky", 64'(err), 64'd1);
    chk("t3_idle", 64'(busy), 64'd0);
    chk("t3_nwrites", 64'(wa.size() - base_n), 64'd0);
    do_start();
    chk("t3_err_clear", 64'(err), 64'd0);

    // Stream gaps, single word (session already started)
    base_n = wa.size();
    send_word(32'h1, 3);
    send_word(32'hDEAD_BEEF, 3);
    tick();
    chk("t4_nwrites", 64'(wa.size() - base_n), 64'd1);
    if (wa.size() == base_n + 1) begin
      chk("t4_addr", 64'(wa[base_n]), 64'h100);
      chk("t4_data", 64'(wd[base_n]), 64'hDEAD_BEEF);
    end

    // Reset after two data bytes
    base_n = wa.size();
    do_start();
    send_word(32'h1, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 64'(in_ready), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_we", 64'(mem_we), 64'd0);
    chk("t5_rst_addr", 64'(mem_addr), 64'd0);
    chk("t5_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_err", 64'(err), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_nowrite", 64'(wa.size() - base_n), 64'd0);
    do_start();
    send_word(32'h1, 0);
    send_word(32'h1122_3344, 0);
    tick();
    chk("t5_nwrites", 64'(wa.size() - base_n), 64'd1);
    if (wa.size() == base_n + 1) begin
      chk("t5_addr", 64'(wa[base_n]), 64'h100);
      chk("t5_data", 64'(wd[base_n]), 64'h1122_3344);
    end

    // start pulsed during DATA is ignored
    base_n = wa.size();
    do_start();
    send_word(32'h3, 0);
    send_word(32'hA1A2_A3A4, 0);
    send(8'hB4, 0);
    start = 1'b1;
    send(8'hB3, 0);
    start = 1'b0;
    send(8'hB2, 0); send(8'hB1, 0);
    send_word(32'hC1C2_C3C4, 0);
    repeat (3) tick();
    chk("t6_nwrites", 64'(wa.size() - base_n), 64'd3);
    if (wa.size() == base_n + 3) begin
      chk("t6_addr0", 64'(wa[base_n]),     64'h100);
      chk("t6_addr1", 64'(wa[base_n + 1]), 64'h104);
      chk("t6_data1", 64'(wd[base_n + 1]), 64'hB1B2_B3B4);
      chk("t6_addr2", 64'(wa[base_n + 2]), 64'h108);
      chk("t6_data2", 64'(wd[base_n + 2]), 64'hC1C2_C3C4);
    end
    chk("t6_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
